channel_test_sequencer: RTL
===========================

CHANNEL_TEST_SEQUENCER -- requirements
Module: channel_test_sequencer

Interface
REQ-001 Parameter GEN_CYCLES, default 3400: length in cycles of each generate phase.
REQ-002 Parameter SETTLE_CYCLES, default 16: idle gap in cycles after each generate phase.
REQ-003 Parameter ANALYZE_CYCLES, default 512: analyze-window length in cycles.
REQ-004 CLK_100MHz  in  1  sole clock; all logic is on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a test run.
REQ-007 abort  in  1  request to stop the current run.
REQ-008 repeat_n  in  4  passes per run; 0 is treated as 1.
REQ-009 channel_mask  in  16  1 = channel excluded from pass/fail.
REQ-010 status_wire  in  16  per-channel wire-test status from the analyzer.
REQ-011 status_gen  in  16  per-channel generator-test status from the analyzer.
REQ-012 enable_generate  out  1  drives the analyzer's enable_generate.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at the end of a run.
REQ-015 aborted  out  1  set when a run ends by abort; cleared at start.
REQ-016 pass  out  1  result of the last run.
REQ-017 result_wire  out  16  accumulated wire status.
REQ-018 result_gen  out  16  accumulated generator status.
REQ-019 fail_count  out  8  number of failing passes, saturating at 255.

Function
REQ-020 States: IDLE, GEN, SETTLE, ANALYZE, EVAL, DONE; enable_generate=1 only in GEN, and it is a registered output.
REQ-021 IDLE with start=1 and abort=0:
- Latch channel_mask and repeat_n.
- Clear result_wire and result_gen to 16'hFFFF, and clear fail_count, pass and aborted.
- Set pass_cnt=0 and go to GEN on the next cycle.
REQ-022 start while busy is ignored; start and abort together in IDLE leave the block in IDLE with no effect.
REQ-023 GEN lasts exactly GEN_CYCLES cycles.
- On the edge leaving GEN, capture snap_wire = status_wire | mask.
- Then go to SETTLE.
REQ-024 SETTLE lasts SETTLE_CYCLES cycles, then go to ANALYZE.
REQ-025 ANALYZE lasts ANALYZE_CYCLES cycles.
- On the edge leaving ANALYZE, capture snap_gen = status_gen | mask.
- Then go to EVAL.
REQ-026 EVAL lasts 1 cycle:
- result_wire &= snap_wire and result_gen &= snap_gen.
- If (snap_wire & snap_gen) != 16'hFFFF, fail_count increments, saturating at 255.
- pass_cnt increments.
REQ-027 From EVAL: if pass_cnt equals the effective repeat_n, go to DONE; otherwise go to GEN.
REQ-028 DONE lasts 1 cycle: done=1, pass = (result_wire & result_gen) == 16'hFFFF, then return to IDLE.
REQ-029 abort in GEN, SETTLE, ANALYZE or EVAL:
- Next state is DONE with aborted=1 and pass=0.
- Results hold their last EVAL values and no partial snapshot is applied.
- enable_generate falls on the next edge.
REQ-030 abort in DONE is ignored.
REQ-031 Masked channels always read 1 in result_wire and result_gen.
REQ-032 Phase counters are 12 bits wide, count down from parameter-1 and reload on each state entry; the parameters lie in 1..4095.
REQ-033 Outputs other than done hold their values in IDLE until the next start.

Reset
REQ-034 RESET=1 forces, at the next edge, from any state:
- state=IDLE and enable_generate=0, busy=0, done=0, aborted=0, pass=0.
- result_wire=result_gen=16'h0000 and fail_count=0.
- All counters are cleared.
REQ-035 RESET mid-run gives no done pulse; RESET has priority over start and abort.

Verification
REQ-036 Check: repeat_n=1, mask=0, status_wire=status_gen=16'hFFFF.
- enable_generate stays high for exactly 3400 cycles.
- done arrives 3400+16+512+1+1 cycles after start.
- pass=1 and fail_count=0.
REQ-037 Check: repeat_n=3, with status_gen[5]=0 during the second pass only.
- result_gen=16'hFFDF, fail_count=1, pass=0.
- enable_generate shows 3 high windows.
REQ-038 Check: mask=16'h0100 with status_wire[8]=0 throughout.
- result_wire=16'hFFFF and pass=1.
REQ-039 Check: abort in cycle 100 of the second GEN phase.
- enable_generate is 0 on the next edge, then done with aborted=1 and pass=0.
- Results equal the pass-1 values.
REQ-040 Check: RESET mid-ANALYZE, then start with repeat_n=0.
- No done pulse before the reset.
- The new run executes exactly 1 pass.
REQ-041 Check: start pulses during GEN, and start+abort together in IDLE.
- Neither has any effect: pass count and outputs are unchanged.

Source files
------------

// File: rtl/channel_test_sequencer.sv
// Channel test sequencer: runs repeat_n passes of generate -> settle -> analyze
// -> evaluate against a channel analyzer. Each pass snapshots the per-channel
// status, folds it into the accumulated results and counts failing passes.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE and
// only when abort is low on the same cycle. abort is sampled every cycle and
// takes effect only in GEN, SETTLE, ANALYZE or EVAL. done pulses for exactly one
// cycle; while done is high, pass and aborted already hold the final result of
// the run, and they keep it until the next accepted start.
//
// state_dbg encoding: 0 IDLE, 1 GEN, 2 SETTLE, 3 ANALYZE, 4 EVAL, 5 DONE.
module channel_test_sequencer #(
  parameter int unsigned GEN_CYCLES     = 3400,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned ANALYZE_CYCLES = 512
) (
  input  logic        CLK_100MHz,
  input  logic        RESET,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  repeat_n,
  input  logic [15:0] channel_mask,
  input  logic [15:0] status_wire,
  input  logic [15:0] status_gen,
  output logic        enable_generate,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        pass,
  output logic [15:0] result_wire,
  output logic [15:0] result_gen,
  output logic [7:0]  fail_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GEN     = 3'd1,
    S_SETTLE  = 3'd2,
    S_ANALYZE = 3'd3,
    S_EVAL    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Phase counters count down from length-1 to 0; 0 marks the last cycle.
  localparam logic [11:0] GEN_LOAD     = 12'(GEN_CYCLES - 1);
  localparam logic [11:0] SETTLE_LOAD  = 12'(SETTLE_CYCLES - 1);
  localparam logic [11:0] ANALYZE_LOAD = 12'(ANALYZE_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic [11:0] phase_cnt;
  logic [3:0]  pass_cnt;
  logic [3:0]  rep_eff;
  logic [15:0] mask_q;
  logic [15:0] snap_wire;
  logic [15:0] snap_gen;

  logic        phase_last;
  logic        start_ok;
  logic        abort_hit;
  logic [15:0] eval_wire;
  logic [15:0] eval_gen;
  logic        eval_fail;
  logic [4:0]  pass_cnt_inc;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  // Next-state decode and the combinational values EVAL folds into the results.
  always_comb begin
    next_state   = state;
    phase_last   = (phase_cnt == 12'd0);
    start_ok     = start & ~abort;
    abort_hit    = 1'b0;
    eval_wire    = result_wire & snap_wire;
    eval_gen     = result_gen & snap_gen;
    eval_fail    = ((snap_wire & snap_gen) != 16'hFFFF);
    pass_cnt_inc = {1'b0, pass_cnt} + 5'd1;
    case (state)
      S_IDLE: begin
        if (start_ok) next_state = S_GEN;
      end
      S_GEN: begin
        if (abort) begin
          abort_hit  = 1'b1;
          next_state = S_DONE;
        end else if (phase_last) begin
          next_state = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          abort_hit  = 1'b1;
          next_state = S_DONE;
        end else if (phase_last) begin
          next_state = S_ANALYZE;
        end
      end
      S_ANALYZE: begin
        if (abort) begin
          abort_hit  = 1'b1;
          next_state = S_DONE;
        end else if (phase_last) begin
          next_state = S_EVAL;
        end
      end
      S_EVAL: begin
        if (abort) begin
          abort_hit  = 1'b1;
          next_state = S_DONE;
        end else if (pass_cnt_inc == {1'b0, rep_eff}) begin
          next_state = S_DONE;
        end else begin
          next_state = S_GEN;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register, phase counter, snapshots and accumulated results.
  always_ff @(posedge CLK_100MHz) begin
    if (RESET) begin
      state           <= S_IDLE;
      enable_generate <= 1'b0;
      aborted         <= 1'b0;
      pass            <= 1'b0;
      result_wire     <= 16'h0000;
      result_gen      <= 16'h0000;
      fail_count      <= 8'd0;
      phase_cnt       <= 12'd0;
      pass_cnt        <= 4'd0;
      rep_eff         <= 4'd0;
      mask_q          <= 16'h0000;
      snap_wire       <= 16'h0000;
      snap_gen        <= 16'h0000;
    end else begin
      state           <= next_state;
      enable_generate <= (next_state == S_GEN);

      // Reload on every state entry, otherwise count down to zero.
      if (next_state != state) begin
        case (next_state)
          S_GEN:     phase_cnt <= GEN_LOAD;
          S_SETTLE:  phase_cnt <= SETTLE_LOAD;
          S_ANALYZE: phase_cnt <= ANALYZE_LOAD;
          default:   phase_cnt <= 12'd0;
        endcase
      end else if (phase_cnt != 12'd0) begin
        phase_cnt <= phase_cnt - 12'd1;
      end

      if (abort_hit) begin
        aborted <= 1'b1;
        pass    <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            mask_q      <= channel_mask;
            rep_eff     <= (repeat_n == 4'd0) ? 4'd1 : repeat_n;
            result_wire <= 16'hFFFF;
            result_gen  <= 16'hFFFF;
            fail_count  <= 8'd0;
            pass        <= 1'b0;
            aborted     <= 1'b0;
            pass_cnt    <= 4'd0;
          end
        end
        S_GEN: begin
          if (!abort && phase_last) snap_wire <= status_wire | mask_q;
        end
        S_ANALYZE: begin
          if (!abort && phase_last) snap_gen <= status_gen | mask_q;
        end
        S_EVAL: begin
          if (!abort) begin
            result_wire <= eval_wire;
            result_gen  <= eval_gen;
            pass_cnt    <= pass_cnt_inc[3:0];
            if (eval_fail && fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            // pass is valid in the same cycle done rises, so it is taken
            // from the freshly folded values rather than the registers.
            if (next_state == S_DONE) pass <= ((eval_wire & eval_gen) == 16'hFFFF);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
